// File: rtl/decode_execute_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : decode_execute_register                                       |
// | Brief    : Decode->Execute pipeline register with load-use bubble insert, |
// |            stall hold, flush squash and a saturating bubble counter.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_execute_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inValid,
  input  logic                      inBranchEnable,
  input  logic                      inMemoryReadEnable,
  input  logic                      inMemoryWriteEnable,
  input  logic                      inRegisterWriteEnable,
  input  logic                      inImmediateEnable,
  input  logic                      inMemoryOrAlu,
  input  logic [1:0]                inAluOperation,
  input  logic [DATA_WIDTH-1:0]     inPc,
  input  logic [DATA_WIDTH-1:0]     inReadData1,
  input  logic [DATA_WIDTH-1:0]     inReadData2,
  input  logic [DATA_WIDTH-1:0]     inImmediate,
  input  logic [REG_ADDR_WIDTH-1:0] inRs1,
  input  logic [REG_ADDR_WIDTH-1:0] inRs2,
  input  logic [REG_ADDR_WIDTH-1:0] inRd,
  input  logic [2:0]                inFunct3,
  input  logic                      inFunct7b5,
  input  logic                      stallIn,
  input  logic                      flushIn,
  output logic                      outValid,
  output logic                      outBranchEnable,
  output logic                      outMemoryReadEnable,
  output logic                      outMemoryWriteEnable,
  output logic                      outRegisterWriteEnable,
  output logic                      outImmediateEnable,
  output logic                      outMemoryOrAlu,
  output logic [1:0]                outAluOperation,
  output logic [DATA_WIDTH-1:0]     outPc,
  output logic [DATA_WIDTH-1:0]     outReadData1,
  output logic [DATA_WIDTH-1:0]     outReadData2,
  output logic [DATA_WIDTH-1:0]     outImmediate,
  output logic [REG_ADDR_WIDTH-1:0] outRs1,
  output logic [REG_ADDR_WIDTH-1:0] outRs2,
  output logic [REG_ADDR_WIDTH-1:0] outRd,
  output logic [2:0]                outFunct3,
  output logic                      outFunct7b5,
  output logic                      stallDecode,
  output logic [COUNT_WIDTH-1:0]    hazardBubbleCount
);

  localparam logic [1:0] c_ALU_BRANCH = 2'b01;

  logic w_rs1Match;
  logic w_rs2Used;
  logic w_rs2Match;
  logic w_loadUseHazard;
  logic w_bubble;
  logic w_countEnable;

  // U/J formats reach here with rs1 = x0, so the rs1 compare never fires for them.
  assign w_rs1Match      = (inRs1 == outRd);
  assign w_rs2Used       = ~inImmediateEnable | inMemoryWriteEnable | (inAluOperation == c_ALU_BRANCH);
  assign w_rs2Match      = w_rs2Used & (inRs2 == outRd);
  assign w_loadUseHazard = outValid & outMemoryReadEnable & (outRd != '0) & inValid
                         & (w_rs1Match | w_rs2Match);

  assign stallDecode   = stallIn | (w_loadUseHazard & ~flushIn);
  assign w_bubble      = flushIn | (~stallIn & w_loadUseHazard);
  assign w_countEnable = ~flushIn & ~stallIn & w_loadUseHazard
                       & (hazardBubbleCount != {COUNT_WIDTH{1'b1}});

  always_ff @(posedge clock) begin
    if (reset || w_bubble) begin
      outValid               <= 1'b0;
      outBranchEnable        <= 1'b0;
      outMemoryReadEnable    <= 1'b0;
      outMemoryWriteEnable   <= 1'b0;
      outRegisterWriteEnable <= 1'b0;
      outImmediateEnable     <= 1'b0;
      outMemoryOrAlu         <= 1'b0;
      outAluOperation        <= 2'b00;
      outPc                  <= '0;
      outReadData1           <= '0;
      outReadData2           <= '0;
      outImmediate           <= '0;
      outRs1                 <= '0;
      outRs2                 <= '0;
      outRd                  <= '0;
      outFunct3              <= 3'b000;
      outFunct7b5            <= 1'b0;
    end else if (!stallIn) begin
      // Control bits are gated by inValid so X from an idle control unit is never latched.
      outValid               <= inValid;
      outBranchEnable        <= inValid & inBranchEnable;
      outMemoryReadEnable    <= inValid & inMemoryReadEnable;
      outMemoryWriteEnable   <= inValid & inMemoryWriteEnable;
      outRegisterWriteEnable <= inValid & inRegisterWriteEnable;
      outImmediateEnable     <= inValid & inImmediateEnable;
      outMemoryOrAlu         <= inValid & inMemoryOrAlu;
      outAluOperation        <= inValid ? inAluOperation : 2'b00;
      outPc                  <= inPc;
      outReadData1           <= inReadData1;
      outReadData2           <= inReadData2;
      outImmediate           <= inImmediate;
      outRs1                 <= inRs1;
      outRs2                 <= inRs2;
      outRd                  <= inRd;
      outFunct3              <= inFunct3;
      outFunct7b5            <= inFunct7b5;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hazardBubbleCount <= '0;
    end else if (w_countEnable) begin
      hazardBubbleCount <= hazardBubbleCount + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_execute_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_decode_execute_register                                    |
// | Brief    : Directed self-checking bench for decode_execute_register.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_decode_execute_register;

  localparam int c_DW = 32;
  localparam int c_AW = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int c_CW = 4;

  logic clock = 1'b0;
  logic reset, inValid, inBranchEnable, inMemoryReadEnable, inMemoryWriteEnable;
  logic inRegisterWriteEnable, inImmediateEnable, inMemoryOrAlu;
  logic [1:0] inAluOperation;
  logic [c_DW-1:0] inPc, inReadData1, inReadData2, inImmediate;
  logic [c_AW-1:0] inRs1, inRs2, inRd;
  logic [2:0] inFunct3;
  logic inFunct7b5, stallIn, flushIn;
  logic outValid, outBranchEnable, outMemoryReadEnable, outMemoryWriteEnable;
  logic outRegisterWriteEnable, outImmediateEnable, outMemoryOrAlu;
  logic [1:0] outAluOperation;
  logic [c_DW-1:0] outPc, outReadData1, outReadData2, outImmediate;
  logic [c_AW-1:0] outRs1, outRs2, outRd;
  logic [2:0] outFunct3;
  logic outFunct7b5, stallDecode;
  logic [c_CW-1:0] hazardBubbleCount;

  int r_vectors = 0;
  int r_miscompares = 0;

  decode_execute_register #(
    .DATA_WIDTH(c_DW), .REG_ADDR_WIDTH(c_AW), .COUNT_WIDTH(c_CW)
  ) dut (
    .clock(clock), .reset(reset), .inValid(inValid),
    .inBranchEnable(inBranchEnable), .inMemoryReadEnable(inMemoryReadEnable),
    .inMemoryWriteEnable(inMemoryWriteEnable), .inRegisterWriteEnable(inRegisterWriteEnable),
    .inImmediateEnable(inImmediateEnable), .inMemoryOrAlu(inMemoryOrAlu),
    .inAluOperation(inAluOperation), .inPc(inPc), .inReadData1(inReadData1),
    .inReadData2(inReadData2), .inImmediate(inImmediate), .inRs1(inRs1), .inRs2(inRs2),
    .inRd(inRd), .inFunct3(inFunct3), .inFunct7b5(inFunct7b5),
    .stallIn(stallIn), .flushIn(flushIn),
    .outValid(outValid), .outBranchEnable(outBranchEnable),
    .outMemoryReadEnable(outMemoryReadEnable), .outMemoryWriteEnable(outMemoryWriteEnable),
    .outRegisterWriteEnable(outRegisterWriteEnable), .outImmediateEnable(outImmediateEnable),
    .outMemoryOrAlu(outMemoryOrAlu), .outAluOperation(outAluOperation), .outPc(outPc),
    .outReadData1(outReadData1), .outReadData2(outReadData2), .outImmediate(outImmediate),
    .outRs1(outRs1), .outRs2(outRs2), .outRd(outRd), .outFunct3(outFunct3),
    .outFunct7b5(outFunct7b5), .stallDecode(stallDecode),
    .hazardBubbleCount(hazardBubbleCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    r_vectors = r_vectors + 1;
    if (observed !== expected) begin
      r_miscompares = r_miscompares + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearIn();
    inValid = 0; inBranchEnable = 0; inMemoryReadEnable = 0; inMemoryWriteEnable = 0;
    inRegisterWriteEnable = 0; inImmediateEnable = 0; inMemoryOrAlu = 0;
    inAluOperation = 2'b00; inPc = '0; inReadData1 = '0; inReadData2 = '0;
    inImmediate = '0; inRs1 = '0; inRs2 = '0; inRd = '0; inFunct3 = '0; inFunct7b5 = 0;
  endtask

  task automatic driveLoad(input logic [c_AW-1:0] rd, input logic [c_DW-1:0] pc);
    clearIn();
    inValid = 1; inMemoryReadEnable = 1; inRegisterWriteEnable = 1; inImmediateEnable = 1;
    inMemoryOrAlu = 1; inAluOperation = 2'b00; inRs1 = 5'd2; inRd = rd; inPc = pc;
    inImmediate = 32'h4; inFunct3 = 3'b010;
  endtask

  task automatic driveAdd(input logic [c_AW-1:0] rs1, input logic [c_AW-1:0] rs2,
                          input logic [c_DW-1:0] pc);
    clearIn();
    inValid = 1; inRegisterWriteEnable = 1; inAluOperation = 2'b10;
    inRs1 = rs1; inRs2 = rs2; inRd = 5'd9; inPc = pc;
  endtask

  initial begin
    clearIn();
    reset = 1; stallIn = 0; flushIn = 0;
    tick(); tick();
    reset = 0;

    // Reset pulse during a stall clears a live instruction
    driveAdd(5'd1, 5'd2, 32'h40);
    tick();
    check("preResetValid", outValid, 1);
    stallIn = 1; reset = 1;
    tick();
    reset = 0; stallIn = 0;
    check("rstValid", outValid, 0);
    check("rstPc", outPc, 0);
    check("rstRegWr", outRegisterWriteEnable, 0);
    check("rstAluOp", outAluOperation, 0);
    check("rstCount", hazardBubbleCount, 0);

    // R-type passes through in one cycle
    clearIn();
    inValid = 1; inRegisterWriteEnable = 1; inAluOperation = 2'b10; inRd = 5'd5;
    inReadData1 = 32'h11; inReadData2 = 32'h22; inPc = 32'h100; inRs1 = 5'd1; inRs2 = 5'd2;
    inFunct7b5 = 1;
    #1 check("rStallDec", stallDecode, 0);
    tick();
    check("rValid", outValid, 1);
    check("rRegWr", outRegisterWriteEnable, 1);
    check("rAluOp", outAluOperation, 2'b10);
    check("rRd", outRd, 5);
    check("rRd1", outReadData1, 32'h11);
    check("rRd2", outReadData2, 32'h22);
    check("rPc", outPc, 32'h100);
    check("rF7", outFunct7b5, 1);

    // Load rd=7 then add rs1=7: one bubble, then the add
    driveLoad(5'd7, 32'h200);
    tick();
    check("ldMemRd", outMemoryReadEnable, 1);
    driveAdd(5'd7, 5'd3, 32'h204);
    #1 check("luStallDec", stallDecode, 1);
    tick();
    check("luBubValid", outValid, 0);
    check("luBubPc", outPc, 0);
    check("luBubMemRd", outMemoryReadEnable, 0);
    check("luCount", hazardBubbleCount, 1);
    check("luStallClr", stallDecode, 0);
    tick();
    check("luAddValid", outValid, 1);
    check("luAddRs1", outRs1, 7);
    check("luAddPc", outPc, 32'h204);

    // Load to x0 never stalls
    driveLoad(5'd0, 32'h300);
    tick();
    driveAdd(5'd0, 5'd0, 32'h304);
    #1 check("x0StallDec", stallDecode, 0);
    tick();
    check("x0Valid", outValid, 1);
    check("x0Count", hazardBubbleCount, 1);

    // addi ignores rs2
    driveLoad(5'd7, 32'h400);
    tick();
    clearIn();
    inValid = 1; inRegisterWriteEnable = 1; inImmediateEnable = 1; inAluOperation = 2'b11;
    inRs1 = 5'd1; inRs2 = 5'd7; inRd = 5'd8; inPc = 32'h404; inImmediate = 32'h7;
    #1 check("immStallDec", stallDecode, 0);
    tick();
    check("immValid", outValid, 1);
    check("immPc", outPc, 32'h404);
    check("immCount", hazardBubbleCount, 1);

    // Store uses rs2 even though an immediate is present
    driveLoad(5'd6, 32'h480);
    tick();
    clearIn();
    inValid = 1; inMemoryWriteEnable = 1; inImmediateEnable = 1; inRs1 = 5'd1; inRs2 = 5'd6;
    #1 check("stRs2StallDec", stallDecode, 1);
    tick();
    check("stRs2Count", hazardBubbleCount, 2);
    tick();
    check("stRs2Valid", outValid, 1);

    // Stall holds for three cycles while inputs change
    stallIn = 1;
    for (int i = 0; i < 3; i++) begin
      driveAdd(5'd10 + 5'(i), 5'd11, 32'h500 + 32'(i));
      #1 check("stlStallDec", stallDecode, 1);
      tick();
      check("stlPc", outPc, 32'h0);
      check("stlMemWr", outMemoryWriteEnable, 1);
    end
    stallIn = 0;

    // Flush together with a load-use hazard
    driveLoad(5'd7, 32'h600);
    tick();
    driveAdd(5'd7, 5'd3, 32'h604);
    flushIn = 1;
    #1 check("flStallDec", stallDecode, 0);
    tick();
    flushIn = 0;
    check("flValid", outValid, 0);
    check("flRegWr", outRegisterWriteEnable, 0);
    check("flCount", hazardBubbleCount, 2);

    // Flush beats stall
    driveAdd(5'd1, 5'd2, 32'h700);
    tick();
    stallIn = 1; flushIn = 1;
    tick();
    stallIn = 0; flushIn = 0;
    check("flStlValid", outValid, 0);
    check("flStlPc", outPc, 0);

    // Idle slot with X ALU class
    clearIn();
    inAluOperation = 2'bxx; inMemoryReadEnable = 1'bx;
    tick();
    check("xAluOp", outAluOperation, 2'b00);
    check("xValid", outValid, 0);
    check("xMemRd", outMemoryReadEnable, 0);

    // Back-to-back dependent loads drive the counter into saturation
    driveLoad(5'd7, 32'h800);
    inRs1 = 5'd7;
    for (int i = 0; i < 40; i++) tick();
    check("satCount", hazardBubbleCount, 4'hF);
    tick(); tick();
    check("satHold", hazardBubbleCount, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
